approx_mult_lsam_pipe: RTL
==========================

APPROX_MULT_LSAM_PIPE -- requirements
Module: approx_mult_lsam_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width; even, >= 4.
REQ-002 SHALL have parameter EXACT_GROUPS, default 1: count of low 2-bit B groups always computed exactly; range 0..WIDTH/2.
REQ-003 SHALL have port clk  input  1: single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1: operand transaction offered.
REQ-006 SHALL have port in_ready  output  1: operand transaction accepted when in_valid & in_ready.
REQ-007 SHALL have port a  input  WIDTH: multiplicand, unsigned.
REQ-008 SHALL have port b  input  WIDTH: multiplier, unsigned.
REQ-009 SHALL have port approx  input  1: 1 = LUT-sharing approximate mode, 0 = exact; sampled per transaction.
REQ-010 SHALL have port out_valid  output  1: result available.
REQ-011 SHALL have port out_ready  input  1: result consumed when out_valid & out_ready.
REQ-012 SHALL have port p  output  2*WIDTH: product, unsigned.

Function
REQ-013 SHALL split b into G = WIDTH/2 groups, group g = b[2g+1:2g].
REQ-014 SHALL form partial product pp_g = a * grp_g, zero-extended to 2*WIDTH, shifted left 2g.
REQ-015 Exact mode SHALL use grp_g = b[2g+1:2g] for all g; p = a*b exactly.
REQ-016 Approx mode SHALL use grp_g = b[2g+1:2g] for g < EXACT_GROUPS and grp_g = {b[2g], b[2g]} for g >= EXACT_GROUPS.
REQ-017 SHALL sum all pp_g modulo 2^(2*WIDTH); no saturation; exact mode never overflows.
REQ-018 Stage 1 SHALL register the G partial products plus the approx flag; stage 2 SHALL register the sum and drive p; latency accept-to-out_valid = 2 cycles with no stall.
REQ-019 Each stage SHALL advance when its downstream slot is empty or is being consumed in the same cycle.
REQ-020 in_ready SHALL equal !s1_valid | s1_advance (combinational from out_ready); full throughput of one result per cycle when out_ready stays high.
REQ-021 While out_valid & !out_ready, p and out_valid SHALL hold stable; no transaction dropped or duplicated; order preserved.
REQ-022 Accept and consume in the same cycle with both stages full SHALL shift both stages; occupancy unchanged.
REQ-023 approx SHALL be honoured per transaction; toggling between consecutive accepts SHALL not affect in-flight results.

Reset
REQ-024 rst_n low SHALL asynchronously clear s1_valid, s2_valid, out_valid=0, p=0; in_ready=1 when rst_n high and pipeline empty.
REQ-025 Reset mid-operation SHALL discard all in-flight transactions; first accept after release follows REQ-018 latency.

Configuration
REQ-026 Macro APPROX_MULT_ERR_STATS_EN SHALL, when defined, add ports stat_clr input 1, err_cnt output 32, err_sum output 32.
REQ-027 With macro: each consumed approx-mode result SHALL be compared with exact a*b carried in the pipeline; mismatch increments err_cnt; |exact - approx| added to err_sum; both saturate at 2^32-1; reset and stat_clr (synchronous, priority over update) clear both to 0.
REQ-028 Without macro: no extra ports, no exact-path logic, behaviour otherwise identical.

Structure
REQ-029 Package approx_mult_pkg SHALL hold the approx mode constants and a function returning the effective 2-bit group for (group, index, mode, EXACT_GROUPS).
REQ-030 Sub-module approx_pp_gen SHALL produce one shifted partial product; instantiated G times by generate.

Verification
REQ-031 WIDTH=4, EXACT_GROUPS=1, approx=1, a=15, b=9 -> p=15 two cycles after accept; with stats, err_cnt=1, err_sum=120.
REQ-032 Same config, approx=1, a=15, b=6 -> p=210; approx=0, a=15, b=6 -> p=90.
REQ-033 WIDTH=8, approx=0, exhaustive a,b with out_ready=1 -> p=a*b every cycle, in_ready constantly 1, one result per cycle.
REQ-034 Random out_ready (50%) over 1000 transactions -> scoreboard order and values match, p stable during stall.
REQ-035 rst_n asserted with both stages full -> out_valid=0, p=0 immediately; next accept produces result after 2 cycles.
REQ-036 EXACT_GROUPS=WIDTH/2, approx=1, random operands -> p=a*b; err_cnt stays 0.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// Shared constants and helpers for the LUT-sharing approximate multiplier.
// Mode encoding of the per-transaction approx input, and the rule that
// picks the effective 2-bit multiplier group for each partial product.
package approx_mult_pkg;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    // Effective 2-bit group: approximate high groups reuse their low bit for
    // both positions, so their partial product is only ever 0 or 3*a.
    function automatic logic [1:0] eff_grp(
        input logic [1:0] grp,
        input int         idx,
        input logic       mode,
        input int         exact_groups
    );
        logic [1:0] r;
        r = grp;
        if (mode == MODE_APPROX && idx >= exact_groups) begin
            r = {grp[0], grp[0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/approx_pp_gen.sv
// One partial product: a times a 2-bit multiplier group, zero-extended to
// the full product width and shifted to the group's bit position.
module approx_pp_gen #(
    parameter int WIDTH = 8,
    parameter int IDX   = 0
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [1:0]         grp_i,
    output logic [2*WIDTH-1:0] pp_o
);
    localparam int PW = 2 * WIDTH;

    logic [PW-1:0] a_ext;
    logic [PW-1:0] prod;

    assign a_ext = {{WIDTH{1'b0}}, a_i};
    assign prod  = a_ext * {{(PW-2){1'b0}}, grp_i};
    assign pp_o  = prod << (2 * IDX);

endmodule

// File: rtl/approx_mult_lsam_pipe.sv
// Two-stage pipelined radix-4 multiplier with an optional approximate mode
// in which the high multiplier groups share a reduced partial-product set.
// Stage 1 holds the partial products, stage 2 holds their sum (drives p).
// Optional: define APPROX_MULT_ERR_STATS_EN to add error statistics
// (stat_clr, err_cnt, err_sum) comparing approx results with a*b.
module approx_mult_lsam_pipe
    import approx_mult_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int EXACT_GROUPS = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               approx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
`ifdef APPROX_MULT_ERR_STATS_EN
    ,
    input  logic               stat_clr,
    output logic [31:0]        err_cnt,
    output logic [31:0]        err_sum
`endif
);
    localparam int G  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;

    logic          s1_valid_q;
    logic          s1_approx_q;
    logic [PW-1:0] pp_q [G];
    logic [PW-1:0] pp_w [G];
    logic          s2_valid_q;
    logic [PW-1:0] p_q;
    logic [PW-1:0] sum_d;
    logic          s1_advance;
    logic          accept;

    // A stage moves forward when the slot after it is empty or draining now.
    assign s1_advance = !s2_valid_q | out_ready;
    assign in_ready   = !s1_valid_q | s1_advance;
    assign accept     = in_valid & in_ready;
    assign out_valid  = s2_valid_q;
    assign p          = p_q;

    for (genvar g = 0; g < G; g++) begin : g_pp
        logic [1:0] grp_eff;
        assign grp_eff = eff_grp(b[2*g+1:2*g], g, approx, EXACT_GROUPS);
        approx_pp_gen #(.WIDTH(WIDTH), .IDX(g)) u_pp (
            .a_i  (a),
            .grp_i(grp_eff),
            .pp_o (pp_w[g])
        );
    end

    // Stage 1: capture the partial products and the mode of an accepted operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_approx_q <= 1'b0;
            // NOTE: data registers are cleared along with the valid bits so no X can ever propagate to p.
            pp_q        <= '{default: '0};
        end else if (in_ready) begin
            // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
            s1_valid_q <= in_valid;
            if (accept) begin
                pp_q        <= pp_w;
                s1_approx_q <= approx;
            end
        end
    end

    // Adder tree: total of the registered partial products, wrapping at 2*WIDTH bits.
    always_comb begin
        // NOTE: default assigned first so the combinational block can never infer a latch.
        sum_d = '0;
        for (int g = 0; g < G; g++) begin
            sum_d = sum_d + pp_q[g];
        end
    end

    // Stage 2: register the sum; holds p and out_valid while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            p_q        <= '0;
        end else if (s1_advance) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                p_q <= sum_d;
            end
        end
    end

`ifdef APPROX_MULT_ERR_STATS_EN
    localparam int SW = ((PW > 32) ? PW : 32) + 1;

    logic [PW-1:0] exact_s1_q;
    logic [PW-1:0] exact_s2_q;
    logic          s2_approx_q;
    logic [31:0]   err_cnt_q;
    logic [31:0]   err_sum_q;
    logic [PW-1:0] diff;
    logic [SW-1:0] sum_wide;
    logic [31:0]   err_cnt_d;
    logic [31:0]   err_sum_d;

    // Carry the exact product alongside the approximate one through both stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exact_s1_q  <= '0;
            exact_s2_q  <= '0;
            s2_approx_q <= 1'b0;
        end else begin
            if (accept) begin
                exact_s1_q <= {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
            end
            if (s1_advance && s1_valid_q) begin
                exact_s2_q  <= exact_s1_q;
                s2_approx_q <= s1_approx_q;
            end
        end
    end

    // Saturating error-count and absolute-error-sum candidates.
    always_comb begin
        diff      = (exact_s2_q >= p_q) ? (exact_s2_q - p_q) : (p_q - exact_s2_q);
        sum_wide  = SW'(err_sum_q) + SW'(diff);
        err_sum_d = (sum_wide > SW'(32'hFFFF_FFFF)) ? 32'hFFFF_FFFF : sum_wide[31:0];
        err_cnt_d = (err_cnt_q == 32'hFFFF_FFFF) ? err_cnt_q : err_cnt_q + 32'd1;
    end

    // Statistics update on each consumed approximate result; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
            err_sum_q <= '0;
        end else if (stat_clr) begin
            err_cnt_q <= '0;
            err_sum_q <= '0;
        end else if (s2_valid_q && out_ready && s2_approx_q && (diff != '0)) begin
            err_cnt_q <= err_cnt_d;
            err_sum_q <= err_sum_d;
        end
    end

    assign err_cnt = err_cnt_q;
    assign err_sum = err_sum_q;
`else
    logic unused_approx;
    assign unused_approx = s1_approx_q;
`endif

endmodule
